// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Groups the boot loader's byte-stream port and its instruction memory write
// port.
//   rx_data    [7:0]   incoming byte
//   rx_valid           rx_data is valid
//   rx_ready           loader accepts the byte (transfer when valid && ready)
//   imem_we            one-cycle instruction memory write strobe
//   imem_waddr [31:0]  word-aligned byte address of the write
//   imem_wdata [31:0]  instruction word to write
// Modports:
//   master - byte sender / memory side (drives rx_data, rx_valid)
//   slave  - the loader (drives rx_ready and the write port)
// -----------------------------------------------------------------------------
interface imem_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Boot-time controller for the writable instruction memory. Receives a byte
// stream (16-bit little-endian word count, then 4*count bytes), validates the
// count, packs little-endian bytes into 32-bit words and writes them to
// consecutive word addresses from byte address 0. The CPU is held until the
// last word has been strobed, then released.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   load_start  single-cycle pulse starting a load (WAIT_START, DONE, ERR only)
//   bus         byte stream in / instruction memory write out (slave modport)
//   cpu_hold    CPU stall, high except in DONE
//   load_done   last load completed successfully
//   load_err    last header was illegal (count 0 or count > DEPTH)
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int DEPTH = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err
);
    localparam int AW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        WAIT_START,
        HDR0,
        HDR1,
        DATA,
        DRAIN,
        DONE,
        ERR
    } state_t;

    state_t         state_reg, state_next;
    logic [15:0]    count_reg, count_next;
    logic [AW-1:0]  word_idx_reg, word_idx_next;
    logic [1:0]     byte_idx_reg, byte_idx_next;
    logic [31:0]    asm_reg, asm_next;
    logic           rx_ready_reg, rx_ready_next;
    logic           imem_we_reg, imem_we_next;
    logic [31:0]    imem_waddr_reg, imem_waddr_next;
    logic [31:0]    imem_wdata_reg, imem_wdata_next;
    logic           cpu_hold_reg, cpu_hold_next;
    logic           load_done_reg, load_done_next;
    logic           load_err_reg, load_err_next;

    logic           xfer;
    logic [15:0]    hdr_count;
    logic [31:0]    asm_shift;
    logic           last_word;

    assign xfer      = bus.rx_valid && rx_ready_reg;
    assign hdr_count = {bus.rx_data, count_reg[7:0]};
    // Bytes enter at the top and shift down, so after four bytes b0 sits in
    // [7:0] and b3 in [31:24].
    assign asm_shift = {bus.rx_data, asm_reg[31:8]};
    assign last_word = ({{(16-AW){1'b0}}, word_idx_reg} == (count_reg - 16'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= WAIT_START;
            count_reg      <= '0;
            word_idx_reg   <= '0;
            byte_idx_reg   <= '0;
            asm_reg        <= '0;
            rx_ready_reg   <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_waddr_reg <= '0;
            imem_wdata_reg <= '0;
            cpu_hold_reg   <= 1'b1;
            load_done_reg  <= 1'b0;
            load_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            word_idx_reg   <= word_idx_next;
            byte_idx_reg   <= byte_idx_next;
            asm_reg        <= asm_next;
            rx_ready_reg   <= rx_ready_next;
            imem_we_reg    <= imem_we_next;
            imem_waddr_reg <= imem_waddr_next;
            imem_wdata_reg <= imem_wdata_next;
            cpu_hold_reg   <= cpu_hold_next;
            load_done_reg  <= load_done_next;
            load_err_reg   <= load_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        word_idx_next   = word_idx_reg;
        byte_idx_next   = byte_idx_reg;
        asm_next        = asm_reg;
        imem_we_next    = 1'b0;
        imem_waddr_next = imem_waddr_reg;
        imem_wdata_next = imem_wdata_reg;

        case (state_reg)
            WAIT_START: begin
                if (load_start) state_next = HDR0;
            end
            HDR0: begin
                if (xfer) begin
                    count_next[7:0] = bus.rx_data;
                    state_next      = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    count_next = hdr_count;
                    if (hdr_count == 16'd0 || hdr_count > 16'(DEPTH)) begin
                        state_next = ERR;
                    end else begin
                        word_idx_next = '0;
                        byte_idx_next = '0;
                        state_next    = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    asm_next      = asm_shift;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        imem_we_next    = 1'b1;
                        imem_wdata_next = asm_shift;
                        imem_waddr_next = 32'({word_idx_reg, 2'b00});
                        word_idx_next   = word_idx_reg + 1'b1;
                        if (last_word) state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE, ERR: begin
                if (load_start) state_next = HDR0;
            end
            default: begin
                state_next = WAIT_START;
            end
        endcase
    end

    // Status outputs are registered copies decoded from the next state, so
    // they change on the same edge as the state itself.
    always_comb begin
        rx_ready_next  = (state_next == HDR0) || (state_next == HDR1) ||
                         (state_next == DATA);
        cpu_hold_next  = (state_next != DONE);
        load_done_next = (state_next == DONE);
        load_err_next  = (state_next == ERR);
    end

    assign bus.rx_ready   = rx_ready_reg;
    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_waddr = imem_waddr_reg;
    assign bus.imem_wdata = imem_wdata_reg;
    assign cpu_hold       = cpu_hold_reg;
    assign load_done      = load_done_reg;
    assign load_err       = load_err_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
    logic clk;
    logic reset;
    logic load_start;
    logic cpu_hold;
    logic load_done;
    logic load_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];   // {addr, data} of every observed write strobe

    imem_boot_loader_if bus();

    imem_boot_loader #(.DEPTH(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe lasts one cycle, so one falling edge sees each write exactly once.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wq.push_back({bus.imem_waddr, bus.imem_wdata});
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        load_start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        logic rdy;
        ok = 1'b0;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rdy = bus.rx_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout byte=%02h rx_ready never high within 200 cycles", b);
        end
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (gaps) begin
                bus.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_nominal_writes(input string tag);
        checks++;
        if (wq.size() !== 2) begin
            errors++;
            $display("FAIL %s_wcount got=%0d exp=2", tag, wq.size());
        end else begin
            checks++;
            if (wq[0] !== {32'h0, 32'h00000613}) begin
                errors++;
                $display("FAIL %s_w0 got=%016h exp=%016h", tag, wq[0], {32'h0, 32'h00000613});
            end
            checks++;
            if (wq[1] !== {32'h4, 32'h00000693}) begin
                errors++;
                $display("FAIL %s_w1 got=%016h exp=%016h", tag, wq[1], {32'h4, 32'h00000693});
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [71:0] got, exp;
        got = {bus.rx_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, cpu_hold, load_done, load_err, 3'b000};
        exp = {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3'b000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%018h exp=%018h", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("wait_start_idle");
    endtask

    task automatic test_nominal();
        logic [7:0] s[$];
        do_reset();
        wq.delete();
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h06, 8'h00, 8'h00, 8'h93, 8'h06, 8'h00};
        send_stream(s, 1'b0);
        send_byte(8'h00);
        bus.rx_valid = 1'b0;
        // Now inside the last strobe cycle.
        checks++;
        if ({bus.imem_we, cpu_hold, load_done} !== 3'b110) begin
            errors++;
            $display("FAIL nominal_last_strobe we,hold,done got=%b exp=110", {bus.imem_we, cpu_hold, load_done});
        end
        @(negedge clk);
        checks++;
        if ({bus.imem_we, cpu_hold, load_done, load_err, bus.rx_ready} !== 5'b00100) begin
            errors++;
            $display("FAIL nominal_done we,hold,done,err,rdy got=%b exp=00100",
                     {bus.imem_we, cpu_hold, load_done, load_err, bus.rx_ready});
        end
        check_nominal_writes("nominal");
    endtask

    task automatic test_hdr_errors();
        logic [7:0] hdr[2][2];
        hdr[0] = '{8'h00, 8'h00};
        hdr[1] = '{8'h81, 8'h00};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            wq.delete();
            pulse_start();
            send_byte(hdr[k][0]);
            send_byte(hdr[k][1]);
            bus.rx_valid = 1'b0;
            checks++;
            if ({load_err, cpu_hold, load_done, bus.rx_ready} !== 4'b1100) begin
                errors++;
                $display("FAIL hdr_err_%0d err,hold,done,rdy got=%b exp=1100", k,
                         {load_err, cpu_hold, load_done, bus.rx_ready});
            end
            repeat (3) @(negedge clk);
            checks++;
            if (wq.size() !== 0) begin
                errors++;
                $display("FAIL hdr_err_%0d_writes got=%0d exp=0", k, wq.size());
            end
        end
    endtask

    // Starts from ERR left by test_hdr_errors; also shows the error clears.
    task automatic test_full_depth();
        int bad;
        logic [31:0] expw;
        wq.delete();
        pulse_start();
        checks++;
        if (load_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b exp=0", load_err);
        end
        send_byte(8'h80);
        send_byte(8'h00);
        for (int i = 0; i < 512; i++) send_byte(8'(i));
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({load_done, load_err, cpu_hold} !== 3'b100) begin
            errors++;
            $display("FAIL full_status done,err,hold got=%b exp=100", {load_done, load_err, cpu_hold});
        end
        checks++;
        if (wq.size() !== 128) begin
            errors++;
            $display("FAIL full_wcount got=%0d exp=128", wq.size());
        end else begin
            checks++;
            if (wq[127] !== {32'h1FC, 32'hFFFEFDFC}) begin
                errors++;
                $display("FAIL full_last got=%016h exp=%016h", wq[127], {32'h1FC, 32'hFFFEFDFC});
            end
            bad = 0;
            for (int k = 0; k < 128; k++) begin
                expw = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                if (wq[k] !== {32'(4*k), expw}) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL full_all_words bad_words got=%0d exp=0", bad);
            end
        end
    endtask

    task automatic test_flow_control();
        logic [7:0] s[$];
        int consumed_early;
        do_reset();
        wq.delete();
        bus.rx_data = 8'h02;
        bus.rx_valid = 1'b1;
        consumed_early = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rx_ready !== 1'b0) consumed_early++;
            @(negedge clk);
        end
        checks++;
        if (consumed_early !== 0) begin
            errors++;
            $display("FAIL flow_prestart rx_ready_high_cycles got=%0d exp=0", consumed_early);
        end
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h06, 8'h00, 8'h00, 8'h93, 8'h06, 8'h00, 8'h00};
        send_stream(s, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL flow_done got=%b exp=1", load_done);
        end
        check_nominal_writes("flow");
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] s[$];
        do_reset();
        wq.delete();
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h06, 8'h00, 8'h00, 8'h93, 8'h06};
        send_stream(s, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midword_async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (wq.size() !== 1) begin
            errors++;
            $display("FAIL midword_no_strobe writes got=%0d exp=1", wq.size());
        end
        wq.delete();
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h06, 8'h00, 8'h00, 8'h93, 8'h06, 8'h00, 8'h00};
        send_stream(s, 1'b0);
        repeat (2) @(negedge clk);
        check_nominal_writes("midword_reload");
    endtask

    task automatic test_restart();
        logic [7:0] s[$];
        do_reset();
        wq.delete();
        pulse_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h06};
        send_stream(s, 1'b0);
        load_start = 1'b1;   // ignored in DATA
        send_byte(8'h00);
        load_start = 1'b0;
        s = '{8'h00, 8'h93, 8'h06, 8'h00, 8'h00};
        send_stream(s, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_ignored_done got=%b exp=1", load_done);
        end
        check_nominal_writes("restart_ignored");
        wq.delete();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cpu_hold, load_done, bus.rx_ready} !== 3'b101) begin
            errors++;
            $display("FAIL restart_from_done hold,done,rdy got=%b exp=101", {cpu_hold, load_done, bus.rx_ready});
        end
        @(negedge clk);
        load_start = 1'b0;
        s = '{8'h01, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        send_stream(s, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (wq.size() !== 1 || wq[0] !== {32'h0, 32'h0000006F}) begin
            errors++;
            $display("FAIL reload_one_word count=%0d first=%016h exp count=1 first=%016h",
                     wq.size(), (wq.size() > 0) ? wq[0] : 64'h0, {32'h0, 32'h0000006F});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        do_reset();
        wq.delete();
        pulse_start();
        s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_stream(s, 1'b0);
        send_byte(8'h44);
        // Strobe cycle of word 0: loader must still be accepting.
        checks++;
        if ({bus.imem_we, bus.rx_ready} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_strobe_ready we,rdy got=%b exp=11", {bus.imem_we, bus.rx_ready});
        end
        s = '{8'h55, 8'h66, 8'h77, 8'h88};
        send_stream(s, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (wq.size() !== 2) begin
            errors++;
            $display("FAIL b2b_wcount got=%0d exp=2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== {32'h0, 32'h44332211} || wq[1] !== {32'h4, 32'h88776655}) begin
                errors++;
                $display("FAIL b2b_data w0=%016h w1=%016h exp w0=%016h w1=%016h",
                         wq[0], wq[1], {32'h0, 32'h44332211}, {32'h4, 32'h88776655});
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hdr_errors();
        test_full_depth();
        test_flow_control();
        test_reset_mid_word();
        test_restart();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
